aixh_mxc_bwd_collector: RTL



---
 rtl/aixh_mxc_bwd_collector.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/aixh_mxc_bwd_collector.sv
// ============================================================================
// aixh_mxc_bwd_collector
// ----------------------------------------------------------------------------
// Left-edge controller for the MxConv upper-cell chain. Jobs from the core
// sequencer are turned into a single csync/command pulse into the first upper
// p-tile. The backward result beats that come back along the chain are
// buffered in a FIFO and presented downstream as a valid/ready stream.
//
// Optional feature macro: AIXH_MXC_BWD_TIMEOUT_EN
//   When defined, a WAIT that sees no beat for TIMEOUT cycles is abandoned:
//   o_err[1] is set, the outstanding reservation is released and the FSM
//   returns to IDLE. When undefined, WAIT lasts until every beat has arrived
//   and o_err[1] is always 0.
//
// Ports
//   aixh_core_clk2x  in   clock
//   aixh_core_rst    in   synchronous active-high reset
//   i_job_vld        in   job request
//   o_job_rdy        out  job accepted on i_job_vld && o_job_rdy
//   i_job_cmd        in   command to broadcast (CWIDTH)
//   i_job_beats      in   backward beats expected, 0..DEPTH
//   o_fwd_csync      out  one-cycle command sync pulse to the chain
//   o_fwd_cmd        out  command to the chain, 0 (NOP) outside the pulse
//   i_bwd_vld        in   backward beat valid (no backpressure)
//   i_bwd_dat        in   backward beat data (DWIDTH)
//   o_res_vld        out  FIFO head valid
//   i_res_rdy        in   downstream pop
//   o_res_dat        out  FIFO head data, 0 while empty
//   o_err            out  sticky errors: [0] unexpected beat, [1] timeout
// ============================================================================
module aixh_mxc_bwd_collector #(
    parameter int CWIDTH  = 32,
    parameter int DWIDTH  = 64,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic                         aixh_core_clk2x,
    input  logic                         aixh_core_rst,
    input  logic                         i_job_vld,
    output logic                         o_job_rdy,
    input  logic [CWIDTH-1:0]            i_job_cmd,
    input  logic [$clog2(DEPTH+1)-1:0]   i_job_beats,
    output logic                         o_fwd_csync,
    output logic [CWIDTH-1:0]            o_fwd_cmd,
    input  logic                         i_bwd_vld,
    input  logic [DWIDTH-1:0]            i_bwd_dat,
    output logic                         o_res_vld,
    input  logic                         i_res_rdy,
    output logic [DWIDTH-1:0]            o_res_dat,
    output logic [1:0]                   o_err
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT
    } state_t;

    state_t              state_q;
    logic [CWIDTH-1:0]   cmd_q;
    logic [CW-1:0]       beats_q;
    logic [CW-1:0]       remain_q;
    logic                csync_q;
    logic [CWIDTH-1:0]   fwd_cmd_q;
    logic                err_unexp_q;
    logic                err_tmo;

    logic [DWIDTH-1:0]   mem_q [DEPTH];
    logic [PW-1:0]       wr_ptr_q;
    logic [PW-1:0]       rd_ptr_q;
    logic [CW-1:0]       count_q;
    logic [CW-1:0]       count_d;

    logic                push;
    logic                pop;
    logic [CW:0]         free_slots;

    // Only beats that arrive while collecting are stored; anything else is
    // dropped and flagged. The pop is allowed whenever the head is valid.
    assign push = (state_q == ST_WAIT) && i_bwd_vld;
    assign pop  = (count_q != '0) && i_res_rdy;

    // Free space seen by a waiting job counts this cycle's pop. No push can
    // happen outside WAIT, so space found now is still there next cycle when
    // the registered csync goes out and the reservation is committed.
    assign free_slots = (CW+1)'(DEPTH) - {1'b0, count_q} + {{CW{1'b0}}, pop};

    assign count_d = count_q + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};

`ifdef AIXH_MXC_BWD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_cnt_q;
    logic          err_tmo_q;
    assign err_tmo = err_tmo_q;
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = TIMEOUT;
    assign err_tmo        = 1'b0;
`endif

    // FIFO pointers and occupancy. Push and pop together at full occupancy
    // are fine: the write lands in the slot being read out this same cycle.
    always_ff @(posedge aixh_core_clk2x) begin
        if (aixh_core_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_d;
        end
    end

    // Storage array; contents need no reset because the head is gated by
    // the occupancy count.
    always_ff @(posedge aixh_core_clk2x) begin
        if (push) begin
            mem_q[wr_ptr_q] <= i_bwd_dat;
        end
    end

    // Job FSM. csync and the command are registered: the space decision is
    // taken one cycle ahead (at the handshake, or in a stalled ISSUE cycle),
    // and the cycle in which csync is high commits remain and the
    // reservation.
    always_ff @(posedge aixh_core_clk2x) begin
        if (aixh_core_rst) begin
            state_q     <= ST_IDLE;
            cmd_q       <= '0;
            beats_q     <= '0;
            remain_q    <= '0;
            csync_q     <= 1'b0;
            fwd_cmd_q   <= '0;
            err_unexp_q <= 1'b0;
`ifdef AIXH_MXC_BWD_TIMEOUT_EN
            tmo_cnt_q   <= '0;
            err_tmo_q   <= 1'b0;
`endif
        end else begin
            if (i_bwd_vld && (state_q != ST_WAIT)) begin
                err_unexp_q <= 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (i_job_vld) begin
                        cmd_q   <= i_job_cmd;
                        beats_q <= i_job_beats;
                        state_q <= ST_ISSUE;
                        if (free_slots >= {1'b0, i_job_beats}) begin
                            csync_q   <= 1'b1;
                            fwd_cmd_q <= i_job_cmd;
                        end
                    end
                end

                ST_ISSUE: begin
                    if (csync_q) begin
                        csync_q   <= 1'b0;
                        fwd_cmd_q <= '0;
                        remain_q  <= beats_q;
                        state_q   <= (beats_q != '0) ? ST_WAIT : ST_IDLE;
`ifdef AIXH_MXC_BWD_TIMEOUT_EN
                        tmo_cnt_q <= '0;
`endif
                    end else if (free_slots >= {1'b0, beats_q}) begin
                        csync_q   <= 1'b1;
                        fwd_cmd_q <= cmd_q;
                    end
                end

                ST_WAIT: begin
                    if (i_bwd_vld) begin
                        remain_q <= remain_q - CW'(1);
                        if (remain_q == CW'(1)) begin
                            state_q <= ST_IDLE;
                        end
`ifdef AIXH_MXC_BWD_TIMEOUT_EN
                        tmo_cnt_q <= '0;
                    end else if (tmo_cnt_q == TW'(TIMEOUT - 1)) begin
                        // Give up on the missing beats; clearing remain
                        // hands their reserved slots back.
                        err_tmo_q <= 1'b1;
                        remain_q  <= '0;
                        state_q   <= ST_IDLE;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + TW'(1);
`endif
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_job_rdy   = (state_q == ST_IDLE);
    assign o_fwd_csync = csync_q;
    assign o_fwd_cmd   = fwd_cmd_q;
    assign o_res_vld   = (count_q != '0);
    assign o_res_dat   = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign o_err       = {err_tmo, err_unexp_q};

endmodule
